fwrisc_fetch_buffer: RTL and testbench
======================================

Name: fwrisc_fetch_buffer

Overview:
- Instruction prefetch buffer between the fwrisc core fetch port (iaddr/ivalid/iready/idata) and a pipelined instruction-memory bus.
- Requests sequential words ahead of the core into a small in-order FIFO, so sequential fetches complete with zero added latency.
- A non-sequential core address (branch, jump, trap, eret) flushes the buffer and restarts the stream.

Parameters:
- DEPTH, 4, buffer entries and max in-flight requests; power of 2, 2..16.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous active-low reset
- core_iaddr  input  32  core fetch address; bits [1:0] ignored
- core_ivalid  input  1  core fetch request
- core_iready  output  1  fetch complete this cycle; core_idata valid
- core_idata  output  32  instruction word for core_iaddr
- mem_addr  output  32  word-aligned request address
- mem_req  output  1  request valid
- mem_gnt  input  1  request accepted when mem_req && mem_gnt
- mem_rvalid  input  1  response valid; in order, one per grant, at least 1 cycle after its grant
- mem_rdata  input  32  response data

Behaviour:
- Reset: clock and reset as named above; reset is asynchronous, active-low (asserted when reset==0).
- Values while reset is asserted: state=IDLE, count=0, outstanding=0, discard=0, head_addr=0, fetch_addr=0, FIFO pointers=0.
- Output values while reset is asserted: core_iready=0, core_idata=0, mem_req=0, mem_addr=0.
- State:
  - head_addr[31:2]: address of the oldest buffered or next-expected word.
  - fetch_addr[31:2]: next address to request.
  - count: number of buffered words.
  - outstanding: granted requests without a response yet.
  - discard: responses still to be dropped.
- States:
  - IDLE: no stream. mem_req=0. Any core_ivalid is a redirect.
  - STREAM: prefetching active.
- Redirect: core_ivalid && (state==IDLE || core_iaddr[31:2]!=head_addr). Same cycle:
  - core_iready=0.
  - Any mem_rvalid this cycle is dropped.
  - Next cycle: count=0, FIFO pointers reset, head_addr=fetch_addr=core_iaddr[31:2], state=STREAM.
  - discard_next = outstanding + (mem_req&&mem_gnt) - mem_rvalid.
  - outstanding keeps normal accounting.
  - A grant in the redirect cycle still increments outstanding and is covered by discard.
- mem_req is registered-state only, with no combinational path from core inputs:
  - mem_req = (state==STREAM) && (count + outstanding < DEPTH).
  - mem_addr = {fetch_addr,2'b00}.
  - On grant: fetch_addr+1 (wraps 0xFFFFFFFC -> 0x00000000), outstanding+1.
- Response (mem_rvalid): outstanding-1.
  - If discard>0 or redirect this cycle: drop the word, discard-1 (when discard>0).
  - Otherwise deliver the word to the FIFO or to the bypass path.
  - mem_rvalid with outstanding==0 (stray, e.g. after reset): ignored, counters unchanged.
- Hit, no redirect, core_iaddr[31:2]==head_addr:
  - FIFO hit (count>0): core_iready=1, core_idata=FIFO head; pop; head_addr+1.
  - Bypass hit (count==0, discard==0, mem_rvalid): core_iready=1, core_idata=mem_rdata; not pushed; head_addr+1.
  - Otherwise core_iready=0, core_idata=0; core waits, no redirect.
- Push/pop timing:
  - Push when a response is accepted and not bypassed.
  - Simultaneous push and FIFO pop: count unchanged.
  - A push with count==DEPTH cannot occur by construction; flag it as an assertion.
- core_iready is combinational from core inputs and registered state; core_idata=0 whenever core_iready=0.
- Latency:
  - Sequential hit: 0 cycles.
  - Cold/redirect: mem_req in cycle R+1; with a 1-cycle memory, core_iready in cycle R+2 via bypass.
- Core drops core_ivalid: prefetch continues until count+outstanding==DEPTH, then holds.

Test Plan:
- Reset then core_ivalid, core_iaddr=0x100; memory grants every cycle, 1-cycle response.
  - Required: mem_addr 0x100,0x104,... from cycle 1; core_iready in cycle 2 with data(0x100).
  - Sequential 0x104,0x108 each complete in one cycle.
- Core stalls (ivalid=0) with DEPTH=4.
  - Required: exactly 4 requests issued, then mem_req=0 with count=4.
  - Next four sequential fetches return back-to-back hits.
- Redirect to 0x200 with outstanding=2 and mem_rvalid in the redirect cycle.
  - Required: 3 old words are never delivered.
  - First delivered word is data(0x200); mem_addr restarts at 0x200.
- Stream from 0xFFFFFFF8.
  - Required: requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; fetch of 0x0 hits without redirect.
- Assert reset mid-stream (count=2, outstanding=2), release, inject 2 stray mem_rvalid.
  - Required: outputs 0 during reset; strays ignored; next fetch behaves as cold start.
- Variable gnt/rvalid delays (random 0-3 stall cycles) with random branches.
  - Required: every core_iready delivers data matching core_iaddr; count+outstanding never exceeds DEPTH.

Source files
------------

// File: rtl/fwrisc_fetch_buffer.sv
// fwrisc_fetch_buffer: sequential instruction prefetch FIFO between the fwrisc fetch port and a pipelined memory bus
module fwrisc_fetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] core_iaddr,
    input  logic        core_ivalid,
    output logic        core_iready,
    output logic [31:0] core_idata,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;
    logic [29:0]   head_q, head_d, fetch_q, fetch_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [31:0]   fifo_q [DEPTH];
    logic [CW:0]   level;
    logic          redirect, hit, gnt, rsp, accept, fifo_hit, byp_hit, push;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^core_iaddr[1:0];

    assign level    = {1'b0, count_q} + {1'b0, outst_q};
    assign mem_req  = (state_q == STREAM) && (level < {1'b0, FULL});
    assign mem_addr = {fetch_q, 2'b00};

    assign redirect = core_ivalid && (state_q == IDLE || core_iaddr[31:2] != head_q);
    assign hit      = core_ivalid && !redirect;
    assign gnt      = mem_req && mem_gnt;
    // responses with nothing outstanding are strays and never touch the counters
    assign rsp      = mem_rvalid && (outst_q != '0);
    assign accept   = rsp && (discard_q == '0) && !redirect;
    assign fifo_hit = hit && (count_q != '0);
    assign byp_hit  = hit && (count_q == '0) && accept;
    assign push     = accept && !byp_hit;

    assign core_iready = fifo_hit || byp_hit;
    assign core_idata  = fifo_hit ? fifo_q[rd_q] : byp_hit ? mem_rdata : '0;

    always_comb begin
        state_d   = redirect ? STREAM : state_q;
        head_d    = redirect ? core_iaddr[31:2] : core_iready ? head_q + 30'd1 : head_q;
        fetch_d   = redirect ? core_iaddr[31:2] : gnt ? fetch_q + 30'd1 : fetch_q;
        outst_d   = outst_q + CW'(gnt) - CW'(rsp);
        // every request still in flight after a redirect belongs to the old stream
        discard_d = redirect ? outst_d : discard_q - CW'(rsp && discard_q != '0);
        count_d   = redirect ? '0 : count_q + CW'(push) - CW'(fifo_hit);
        wr_d      = redirect ? '0 : wr_q + AW'(push);
        rd_d      = redirect ? '0 : rd_q + AW'(fifo_hit);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            head_q    <= '0;
            fetch_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            head_q    <= head_d;
            fetch_q   <= fetch_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_q] <= mem_rdata;
    end

    assert property (@(posedge clock) disable iff (!reset) !(push && count_q == FULL));
    assert property (@(posedge clock) disable iff (!reset) level <= {1'b0, FULL});
endmodule

// File: tb/tb_fwrisc_fetch_buffer.sv
// tb_fwrisc_fetch_buffer: directed and randomized fetch streams against a pipelined memory model, scoreboard-checked
module tb_fwrisc_fetch_buffer;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] core_iaddr = '0;
    logic        core_ivalid = 1'b0;
    logic        core_iready;
    logic [31:0] core_idata;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    fwrisc_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .core_iaddr(core_iaddr), .core_ivalid(core_ivalid),
        .core_iready(core_iready), .core_idata(core_idata),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {logic [31:0] a; logic [31:0] d;} exp_t;
    typedef struct {logic [31:0] a; int rdy;} pend_t;
    typedef struct {string n; logic [31:0] act; logic [31:0] req;} chk_t;

    exp_t        exp_q[$];
    pend_t       pend[$];
    chk_t        chk_q[$];
    logic [31:0] gnt_log[$];

    int n_vec = 0, n_err = 0, zero_viol = 0, max_inflight = 0;
    int cyc = 0, stray_n = 0, lat_extra = 0;
    bit rnd_gnt = 1'b0, rnd_lat = 1'b0, done = 1'b0;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        chk_q.push_back('{n, act, req});
    endtask

    task automatic fetch(input logic [31:0] a, output int lat);
        exp_q.push_back('{a, dat(a)});
        core_ivalid = 1'b1;
        core_iaddr  = a;
        lat = 0;
        forever begin
            @(negedge clock);
            if (core_iready) break;
            lat++;
            if (lat > 200) begin
                $display("FAIL fetch_timeout: addr %h got no core_iready in 200 cycles, required completion", a);
                $fatal(1, "bench aborted");
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic settle(input int n);
        core_ivalid = 1'b0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    // pipelined memory: in-order responses, at least one cycle after grant
    initial begin
        bit stray_now;
        stray_now = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) pend.delete();
            else begin
                if (mem_rvalid && !stray_now) void'(pend.pop_front());
                if (mem_req && mem_gnt) begin
                    pend.push_back('{mem_addr, cyc + 1 + (rnd_lat ? int'($urandom_range(0, 3)) : lat_extra)});
                    gnt_log.push_back(mem_addr);
                end
                if (pend.size() > max_inflight) max_inflight = pend.size();
            end
            @(posedge clock); #1;
            cyc++;
            stray_now = stray_n > 0;
            if (stray_now) begin
                stray_n--;
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD0_0000 | 32'(cyc);
            end else if (pend.size() > 0 && pend[0].rdy <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = dat(pend[0].a);
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
            mem_gnt = rnd_gnt ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // scoreboard monitor: owns every comparison and the summary
    initial begin
        chk_t c;
        exp_t e;
        forever begin
            @(negedge clock);
            if (core_iready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_iready: got addr %h data %h, required no completion", core_iaddr, core_idata);
                end else begin
                    e = exp_q.pop_front();
                    if (core_idata !== e.d || core_iaddr !== e.a) begin
                        n_err++;
                        $display("FAIL fetch_data: got addr %h data %h, required addr %h data %h", core_iaddr, core_idata, e.a, e.d);
                    end
                end
            end else if (core_idata !== 32'h0) zero_viol++;
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_vec++;
                if (c.act !== c.req) begin
                    n_err++;
                    $display("FAIL %s: got %h, required %h", c.n, c.act, c.req);
                end
            end
            if (done) begin
                n_vec++;
                if (zero_viol != 0) begin
                    n_err++;
                    $display("FAIL idata_zero_when_idle: got %0d cycles with nonzero data, required 0", zero_viol);
                end
                n_vec++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL pending_fetches: got %0d undelivered, required 0", exp_q.size());
                end
                n_vec++;
                if (max_inflight > DEPTH) begin
                    n_err++;
                    $display("FAIL max_inflight: got %0d, required <= %0d", max_inflight, DEPTH);
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

    initial begin
        int lat, mark;
        logic [31:0] pc;
        repeat (3) @(posedge clock);
        #1;
        core_ivalid = 1'b1;
        core_iaddr  = 32'h100;
        @(negedge clock);
        chk("rst_iready", 32'(core_iready), 32'h0);
        chk("rst_idata", core_idata, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;

        // cold start, then sequential hits
        fetch(32'h100, lat); chk("cold_latency", lat, 2);
        chk("first_mem_addr", gnt_log[0], 32'h100);
        fetch(32'h104, lat); chk("seq_latency_104", lat, 0);
        fetch(32'h108, lat); chk("seq_latency_108", lat, 0);
        chk("mem_addr_seq", gnt_log[2], 32'h108);

        // core stall: prefetch tops out at DEPTH buffered words
        settle(10);
        chk("stall_grants", gnt_log.size(), 7);
        chk("stall_last_addr", gnt_log[$], 32'h118);
        @(negedge clock);
        chk("stall_mem_req", 32'(mem_req), 32'h0);
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) begin
            fetch(32'h10C + 32'(i) * 4, lat);
            chk("buffered_hit_latency", lat, 0);
        end

        // redirect with two requests outstanding and a response in the redirect cycle
        settle(10);
        lat_extra = 1;
        fetch(32'h300, lat);
        fetch(32'h304, lat); chk("lat2_bypass", lat, 0);
        chk("outstanding_at_redirect", pend.size(), 2);
        mark = gnt_log.size();
        fetch(32'h200, lat);
        chk("redirect_cycle_grant", gnt_log[mark], 32'h310);
        chk("redirect_restart_addr", gnt_log[mark + 1], 32'h200);
        fetch(32'h204, lat); chk("post_redirect_seq", lat, 0);

        // address wrap
        lat_extra = 0;
        settle(10);
        mark = gnt_log.size();
        fetch(32'hFFFF_FFF8, lat); chk("wrap_cold_latency", lat, 2);
        fetch(32'hFFFF_FFFC, lat); chk("wrap_seq_latency", lat, 0);
        fetch(32'h0000_0000, lat); chk("wrap_zero_no_redirect", lat, 0);
        fetch(32'h0000_0004, lat);
        chk("wrap_req0", gnt_log[mark], 32'hFFFF_FFF8);
        chk("wrap_req1", gnt_log[mark + 1], 32'hFFFF_FFFC);
        chk("wrap_req2", gnt_log[mark + 2], 32'h0000_0000);

        // reset mid-stream, then stray responses
        settle(10);
        lat_extra = 1;
        core_ivalid = 1'b1;
        core_iaddr  = 32'h400;
        @(posedge clock); #1;
        core_ivalid = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        chk("outstanding_pre_reset", pend.size(), 2);
        reset = 1'b0;
        core_ivalid = 1'b1;
        core_iaddr  = 32'h404;
        @(negedge clock);
        chk("midrst_iready", 32'(core_iready), 32'h0);
        chk("midrst_idata", core_idata, 32'h0);
        chk("midrst_mem_req", 32'(mem_req), 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        core_ivalid = 1'b0;
        lat_extra = 0;
        @(negedge clock);
        stray_n = 2;
        repeat (2) begin
            @(negedge clock);
            chk("stray_mem_req", 32'(mem_req), 32'h0);
            chk("stray_iready", 32'(core_iready), 32'h0);
        end
        @(posedge clock); #1;
        fetch(32'h500, lat); chk("post_stray_cold_latency", lat, 2);
        fetch(32'h504, lat); chk("post_stray_seq", lat, 0);

        // random memory stalls and branches
        rnd_gnt = 1'b1;
        rnd_lat = 1'b1;
        pc = 32'h2000;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) pc = 32'h2000 + 32'($urandom_range(0, 1023)) * 4;
            if ($urandom_range(0, 19) == 0) pc = 32'hFFFF_FFF4;
            fetch(pc, lat);
            pc = pc + 4;
            if ($urandom_range(0, 7) == 0) settle(1 + $urandom_range(0, 5));
        end
        rnd_gnt = 1'b0;
        rnd_lat = 1'b0;
        settle(20);
        done = 1'b1;
        repeat (20) @(posedge clock);
        $display("FAIL watchdog: monitor did not reach summary, required finish");
        $fatal(1, "bench aborted");
    end
endmodule
